// File: rtl/down_timer_pkg.sv
// Shared constants for the down_timer block: FSM state encoding.
package down_timer_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/down_timer_tick_gen.sv
// Prescaler for down_timer: one tick every prescale+1 enabled cycles.
module tick_gen #(
   parameter int unsigned pre_len = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clr,
   input  logic [pre_len-1:0] prescale,
   output logic               tick
);

   logic [pre_len-1:0] r_cnt;
   logic               w_hit;

   // >= keeps the divider from running the long way round if prescale shrinks mid-period
   assign w_hit = (r_cnt >= prescale);
   assign tick  = en & ~clr & w_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         if (w_hit) r_cnt <= '0;
         else       r_cnt <= r_cnt + pre_len'(1);
      end
   end

endmodule

// File: rtl/down_timer.sv
// Prescaled down counter with one-shot/periodic reload and a registered terminal-count pulse.
module down_timer
   import down_timer_pkg::*;
#(
   parameter int unsigned len     = 4,
   parameter int unsigned pre_len = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               p_load,
   input  logic [len-1:0]     p_load_data,
   input  logic               auto_reload,
   input  logic [pre_len-1:0] prescale,
   output logic [len-1:0]     out,
   output logic               tc,
   output logic               busy
);

   logic [1:0]     r_state;
   logic [len-1:0] r_count;
   logic [len-1:0] r_reload;
   logic           r_tc;
   logic           r_busy;

   logic [1:0]     w_state_nxt;
   logic [len-1:0] w_count_nxt;
   logic [len-1:0] w_reload_nxt;
   logic           w_tc_nxt;
   logic           w_stop_act;
   logic           w_start_act;
   logic           w_clr;
   logic           w_tick;

   // Which control inputs actually take effect this cycle; any of them restarts the prescaler
   assign w_stop_act  = stop & (r_state == ST_RUN);
   assign w_start_act = start & (r_state != ST_RUN) & ((r_count != '0) | (r_reload != '0));
   assign w_clr       = w_stop_act | p_load | w_start_act;

   tick_gen #(
      .pre_len (pre_len)
   ) u_tick_gen (
      .clk      (clk),
      .reset    (reset),
      .en       (r_state == ST_RUN),
      .clr      (w_clr),
      .prescale (prescale),
      .tick     (w_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_tc     <= w_tc_nxt;
         r_busy   <= (w_state_nxt == ST_RUN);
      end
   end

   // Next state: stop > p_load > start > tick
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_tc_nxt     = 1'b0;
      if (w_stop_act) begin
         w_state_nxt = ST_IDLE;
      end else if (p_load) begin
         w_count_nxt  = p_load_data;
         w_reload_nxt = p_load_data;
         if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
      end else if (w_start_act) begin
         if (r_count == '0) w_count_nxt = r_reload;
         w_state_nxt = ST_RUN;
      end else if (w_tick) begin
         if (r_count > len'(1)) begin
            w_count_nxt = r_count - len'(1);
         end else if (r_count == len'(1)) begin
            w_tc_nxt = 1'b1;
            if (auto_reload && (r_reload != '0)) begin
               w_count_nxt = r_reload;
            end else begin
               w_count_nxt = '0;
               w_state_nxt = ST_DONE;
            end
         end else begin
            // Zero loaded while running: finish quietly, no pulse
            w_state_nxt = ST_DONE;
         end
      end
   end

   assign out  = r_count;
   assign tc   = r_tc;
   assign busy = r_busy;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed table, corner sequences and randomized model comparison.
module tb_down_timer;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       p_load;
   logic [3:0] p_load_data;
   logic       auto_reload;
   logic [3:0] prescale;
   logic [3:0] out;
   logic       tc;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   int m_st      = M_IDLE;
   int m_count   = 0;
   int m_reload  = 0;
   int m_elapsed = 0;
   int m_tc      = 0;

   typedef struct {
      logic       rst;
      logic       st;
      logic       sp;
      logic       ld;
      logic [3:0] data;
      logic [3:0] e_out;
      logic       e_tc;
      logic       e_busy;
   } vec_t;

   vec_t tbl[23];

   down_timer #(.len(4), .pre_len(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .p_load      (p_load),
      .p_load_data (p_load_data),
      .auto_reload (auto_reload),
      .prescale    (prescale),
      .out         (out),
      .tc          (tc),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: timer described as elapsed-cycles arithmetic on plain integers
   task automatic model_step();
      m_tc = 0;
      if (reset) begin
         m_st = M_IDLE; m_count = 0; m_reload = 0; m_elapsed = 0;
      end else if (stop && m_st == M_RUN) begin
         m_st = M_IDLE; m_elapsed = 0;
      end else if (p_load) begin
         m_count = int'(p_load_data); m_reload = int'(p_load_data); m_elapsed = 0;
         if (m_st == M_DONE) m_st = M_IDLE;
      end else if (start && m_st != M_RUN && (m_count != 0 || m_reload != 0)) begin
         if (m_count == 0) m_count = m_reload;
         m_st = M_RUN; m_elapsed = 0;
      end else if (m_st == M_RUN) begin
         if (m_elapsed < int'(prescale)) begin
            m_elapsed++;
         end else begin
            m_elapsed = 0;
            if (m_count > 1) begin
               m_count--;
            end else if (m_count == 1) begin
               m_tc = 1;
               if (auto_reload && m_reload != 0) m_count = m_reload;
               else begin m_count = 0; m_st = M_DONE; end
            end else begin
               m_st = M_DONE;
            end
         end
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobes_off();
      reset = 1'b0; start = 1'b0; stop = 1'b0; p_load = 1'b0;
   endtask

   task automatic do_reset();
      strobes_off(); reset = 1'b1; step(); reset = 1'b0;
   endtask

   task automatic load_start(input logic [3:0] d, input logic [3:0] pre, input logic ar);
      prescale = pre; auto_reload = ar; p_load_data = d;
      p_load = 1'b1; step(); p_load = 1'b0;
      start = 1'b1; step(); start = 1'b0;
   endtask

   initial begin
      int hi;
      strobes_off();
      p_load_data = '0; auto_reload = 1'b0; prescale = '0;

      // rst st sp ld data | out tc busy
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd4, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1};
      tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1};
      tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};

      @(posedge clk);
      #1;
      for (int i = 0; i < 23; i++) begin
         reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp;
         p_load = tbl[i].ld; p_load_data = tbl[i].data;
         step();
         chk($sformatf("tbl[%0d].out", i),  8'(out),  8'(tbl[i].e_out));
         chk($sformatf("tbl[%0d].tc", i),   8'(tc),   8'(tbl[i].e_tc));
         chk($sformatf("tbl[%0d].busy", i), 8'(busy), 8'(tbl[i].e_busy));
      end

      // Divide by 3: a decrement every third cycle, expiry 9 cycles after RUN entry
      do_reset();
      load_start(4'd3, 4'd2, 1'b0);
      chk("pre2.entry_out", 8'(out), 8'd3);
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("pre2.out[%0d]", k), 8'(out), 8'(3 - k / 3));
         chk($sformatf("pre2.tc[%0d]", k),  8'(tc),  8'(k == 9));
      end
      chk("pre2.busy_end", 8'(busy), 8'd0);

      // Periodic mode: 2,1,3 repeating with tc on the reload
      do_reset();
      load_start(4'd3, 4'd0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         step();
         chk($sformatf("auto.out[%0d]", k),  8'(out),  8'((k % 3 == 0) ? 3 : 3 - (k % 3)));
         chk($sformatf("auto.tc[%0d]", k),   8'(tc),   8'(k % 3 == 0));
         chk($sformatf("auto.busy[%0d]", k), 8'(busy), 8'd1);
      end

      // stop beats p_load; resume keeps the count and the old reload
      do_reset();
      load_start(4'd8, 4'd0, 1'b0);
      step(); step();
      chk("stopld.before", 8'(out), 8'd6);
      stop = 1'b1; p_load = 1'b1; p_load_data = 4'd9;
      step();
      strobes_off();
      chk("stopld.out", 8'(out), 8'd6);
      chk("stopld.busy", 8'(busy), 8'd0);
      auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      chk("resume.out", 8'(out), 8'd6);
      chk("resume.busy", 8'(busy), 8'd1);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk($sformatf("resume.out[%0d]", k), 8'(out), 8'((k == 6) ? 8 : 6 - k));
         chk($sformatf("resume.tc[%0d]", k),  8'(tc),  8'(k == 6));
      end

      // Maximum prescale: the first decrement lands 16 cycles after entry
      do_reset();
      load_start(4'd15, 4'd15, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         step();
         chk($sformatf("max.out[%0d]", k), 8'(out), 8'((k < 16) ? 15 : 14));
      end

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset  = ($urandom_range(199, 0) == 0);
         stop   = ($urandom_range(15, 0) == 0);
         p_load = ($urandom_range(11, 0) == 0);
         start  = ($urandom_range(5, 0) == 0);
         p_load_data = 4'($urandom_range(15, 0));
         if ($urandom_range(31, 0) == 0) auto_reload = ~auto_reload;
         if ($urandom_range(7, 0) == 0) begin
            hi = (m_elapsed > 3) ? 15 : 3;
            prescale = 4'($urandom_range(hi, m_elapsed));
         end
         step();
         chk("rnd.out",  8'(out),  8'(m_count));
         chk("rnd.tc",   8'(tc),   8'(m_tc));
         chk("rnd.busy", 8'(busy), 8'(m_st == M_RUN));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
